fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 17 +
 rtl/fetch_perf_counter.sv | 22 ++
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, reset PC, PC step and FSM state encoding for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int          WORD_W       = 32;
  localparam int          ADDR_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP      = 4;
  localparam int          PERF_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating count of instructions consumed downstream (built only with FETCH_PERF_CNT_EN).
module fetch_perf_counter
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  output logic [PERF_W-1:0] cnt_o
);

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_o <= '0;
    else if (inc_i)
      cnt_o <= sat_inc(cnt_o);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-outstanding imem requests, one-entry output register, branch redirect.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt_o (saturating consumed-instruction count).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              WORD     = WORD_W,
  parameter int              ADDR     = ADDR_W,
  parameter logic [ADDR-1:0] RESET_PC = ADDR'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_o,
  output logic [ADDR-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [WORD-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] branch_pc_i,
  output logic            v_o,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetch_cnt_o
`endif
);

  fetch_state_t    state, state_nxt;
  logic [ADDR-1:0] fetch_pc, redirect_pc, branch_tgt;
  logic            consume, out_free;
  logic            capture, load_target, hold_target, flush_done;

  assign consume     = v_o & ~stall_i;
  assign out_free    = ~v_o | ~stall_i;
  assign branch_tgt  = branch_pc_i & ~ADDR'(3);
  assign imem_addr_o = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // A branch that lands while a request is in flight parks its target in
  // redirect_pc so the address stays stable until the stale response arrives.
  always_comb begin
    state_nxt   = state;
    imem_req_o  = 1'b0;
    capture     = 1'b0;
    load_target = 1'b0;
    hold_target = 1'b0;
    flush_done  = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt   = REQ;
        load_target = branch_i;
      end
      REQ: begin
        imem_req_o = out_free;
        if (branch_i) begin
          if (out_free && !imem_ack_i) begin
            state_nxt   = FLUSH;
            hold_target = 1'b1;
          end else begin
            state_nxt   = REQ;
            load_target = 1'b1;
          end
        end else if (!out_free) begin
          state_nxt = HOLD;
        end else if (imem_ack_i) begin
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (branch_i || out_free)
          state_nxt = REQ;
        load_target = branch_i;
      end
      FLUSH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i)
          state_nxt = REQ;
        if (branch_i) begin
          load_target = imem_ack_i;
          hold_target = ~imem_ack_i;
        end else begin
          flush_done = imem_ack_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      redirect_pc <= '0;
      v_o         <= 1'b0;
      inst_o      <= '0;
      pc_o        <= '0;
    end else begin
      if (branch_i)
        v_o <= 1'b0;
      else if (capture)
        v_o <= 1'b1;
      else if (consume)
        v_o <= 1'b0;

      if (capture) begin
        inst_o <= imem_rdata_i;
        pc_o   <= fetch_pc;
      end

      if (load_target)
        fetch_pc <= branch_tgt;
      else if (capture)
        fetch_pc <= fetch_pc + ADDR'(PC_STEP);
      else if (flush_done)
        fetch_pc <= redirect_pc;

      if (hold_target)
        redirect_pc <= branch_tgt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_perf (
    .clk   (clk),
    .reset (reset),
    .inc_i (consume),
    .cnt_o (perf_fetch_cnt_o)
  );
`endif

endmodule
